// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: per-channel flip-flop synchroniser, tick-qualified
// debounce counter and registered rise/fall edge pulses.
module sync_debounce #(
    parameter int unsigned     CH       = 4,
    parameter int unsigned     STAGES   = 2,
    parameter int unsigned     DB_COUNT = 16,
    parameter logic [CH-1:0]   RST_VAL  = {CH{1'b0}}
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [CH-1:0] d,
    input  logic          tick,
    output logic [CH-1:0] q,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy
);

    localparam int unsigned   CW   = $clog2(DB_COUNT + 1);
    localparam logic [CW-1:0] TERM = CW'(DB_COUNT - 1);

    logic [CH-1:0] sync_q [STAGES];
    logic [CH-1:0] s;
    logic [CW-1:0] cnt [CH];
    logic [CW-1:0] cnt_next [CH];
    logic [CH-1:0] q_next;
    logic [CH-1:0] rise_next;
    logic [CH-1:0] fall_next;
    logic [CH-1:0] busy_next;

    assign s = sync_q[STAGES-1];

    // Synchroniser chain, preset to the reset level so release is pulse-free.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Debounce decision; busy follows the post-edge counter so it drops with the q update.
    always_comb begin
        q_next    = q;
        rise_next = '0;
        fall_next = '0;
        busy_next = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_next[i] = cnt[i];
            if (s[i] == q[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (cnt[i] == TERM) begin
                    cnt_next[i]  = '0;
                    q_next[i]    = s[i];
                    rise_next[i] = s[i];
                    fall_next[i] = ~s[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
            busy_next[i] = (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
            q    <= RST_VAL;
            rise <= '0;
            fall <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            q    <= q_next;
            rise <= rise_next;
            fall <= fall_next;
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_sync_debounce;

    localparam int unsigned CH       = 4;
    localparam int unsigned STAGES   = 2;
    localparam int unsigned DB_COUNT = 4;
    localparam logic [CH-1:0] RST_VAL = 4'b0000;

    logic          ck = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] d = '0;
    logic          tick = 1'b1;
    logic [CH-1:0] q, rise, fall, busy;

    int errors = 0;
    int checks = 0;
    int tick_mode = 0;
    int tphase = 0;
    bit cmp_on = 1'b0;

    sync_debounce #(
        .CH(CH), .STAGES(STAGES), .DB_COUNT(DB_COUNT), .RST_VAL(RST_VAL)
    ) dut (
        .ck(ck), .rst(rst), .d(d), .tick(tick),
        .q(q), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: input delayed by STAGES edges; a level is accepted once it has
    // differed from q on DB_COUNT tick-qualified edges without ever matching q in between.
    logic [CH-1:0] hist [STAGES];
    logic [CH-1:0] m_s, mq, mrise, mfall, mbusy;
    int            mticks [CH];

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) hist[k] = RST_VAL;
            mq = RST_VAL; mrise = '0; mfall = '0; mbusy = '0;
            for (int i = 0; i < CH; i++) mticks[i] = 0;
        end else begin
            m_s = hist[STAGES-1];
            mrise = '0; mfall = '0;
            for (int i = 0; i < CH; i++) begin
                if (m_s[i] == mq[i]) begin
                    mticks[i] = 0;
                end else if (tick) begin
                    mticks[i] = mticks[i] + 1;
                    if (mticks[i] == DB_COUNT) begin
                        mq[i] = m_s[i];
                        if (m_s[i]) mrise[i] = 1'b1; else mfall[i] = 1'b1;
                        mticks[i] = 0;
                    end
                end
                mbusy[i] = (mticks[i] != 0);
            end
            for (int k = STAGES - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
        end
    end

    always @(negedge ck) begin
        if (cmp_on) begin
            chk("model_q",    8'(q),    8'(mq));
            chk("model_rise", 8'(rise), 8'(mrise));
            chk("model_fall", 8'(fall), 8'(mfall));
            chk("model_busy", 8'(busy), 8'(mbusy));
        end
    end

    // Tick source: 0 = always high, 1 = every 4th cycle, 2 = random.
    initial begin
        forever begin
            @(posedge ck); #2;
            case (tick_mode)
                0: tick = 1'b1;
                1: begin tphase = (tphase + 1) % 4; tick = (tphase == 0); end
                default: tick = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic edge_drive();
        @(posedge ck); #2;
    endtask

    task automatic edge_sample();
        @(posedge ck); #1;
    endtask

    initial begin
        int n, nr, at;
        bit seen_busy, bad;
        #1 rst = 1'b1;
        d = 4'b1111;
        cmp_on = 1'b1;
        repeat (3) edge_drive();
        chk("rst_q", 8'(q), 8'h00);
        chk("rst_rise", 8'(rise), 8'h00);
        chk("rst_fall", 8'(fall), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);

        // Release with d=1111: accepted on edge 6.
        rst = 1'b0;
        repeat (5) edge_sample();
        chk("rel_q_e5", 8'(q), 8'h00);
        edge_sample();
        chk("rel_q_e6", 8'(q), 8'h0F);
        chk("rel_rise_e6", 8'(rise), 8'h0F);
        edge_sample();
        chk("rel_rise_e7", 8'(rise), 8'h00);

        // Fall latency on channel 2.
        edge_drive();
        d = 4'b1011;
        repeat (5) edge_sample();
        chk("fall_q_e5", 8'(q[2]), 8'h01);
        chk("fall_busy_e5", 8'(busy[2]), 8'h01);
        edge_sample();
        chk("fall_q_e6", 8'(q), 8'h0B);
        chk("fall_pulse_e6", 8'(fall), 8'h04);
        chk("fall_busy_e6", 8'(busy[2]), 8'h00);
        edge_sample();
        chk("fall_pulse_e7", 8'(fall), 8'h00);

        // Glitch on channel 0 from a settled low level.
        edge_drive();
        d = 4'b0000;
        repeat (10) edge_drive();
        chk("glitch_pre_q", 8'(q), 8'h00);
        d[0] = 1'b1;
        repeat (3) edge_drive();
        d[0] = 1'b0;
        seen_busy = 1'b0; bad = 1'b0;
        for (int e = 0; e < 10; e++) begin
            edge_sample();
            if (busy[0]) seen_busy = 1'b1;
            if (q[0] || rise[0]) bad = 1'b1;
        end
        chk("glitch_busy_seen", 8'(seen_busy), 8'h01);
        chk("glitch_no_change", 8'(bad), 8'h00);

        // Tick gated to every 4th cycle.
        tick_mode = 1;
        edge_drive();
        edge_drive();
        d = 4'b0010;
        n = 0;
        while (!q[1] && n < 40) begin
            edge_sample();
            n++;
        end
        chk("gate_q1", 8'(q[1]), 8'h01);
        chk("gate_latency", 8'(n >= 14 && n <= 19), 8'h01);

        // Reset asserted mid-count on channel 3.
        tick_mode = 0;
        repeat (2) edge_drive();
        d = 4'b1010;
        repeat (4) edge_sample();
        chk("midrst_busy_pre", 8'(busy[3]), 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("midrst_q", 8'(q), 8'h00);
        chk("midrst_busy", 8'(busy), 8'h00);
        repeat (2) edge_drive();
        rst = 1'b0;
        nr = 0; at = 0;
        for (int e = 1; e <= 12; e++) begin
            edge_sample();
            if (rise[3]) begin nr++; at = e; end
        end
        chk("midrst_rise_cnt", 8'(nr), 8'h01);
        chk("midrst_rise_at", 8'(at), 8'h06);

        // Simultaneous rise on 1 and fall on 3.
        edge_drive();
        d = 4'b1000;
        repeat (10) edge_drive();
        chk("simul_pre_q", 8'(q), 8'h08);
        d = 4'b0010;
        repeat (5) edge_sample();
        chk("simul_quiet_e5", 8'({rise, fall}), 8'h00);
        edge_sample();
        chk("simul_rise", 8'(rise), 8'h02);
        chk("simul_fall", 8'(fall), 8'h08);
        chk("simul_q", 8'(q), 8'h02);

        // Randomized run against the model.
        tick_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            edge_drive();
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 39) == 0) d[i] = ~d[i];
            end
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1;
                chk("rand_rst_q", 8'(q), 8'(RST_VAL));
                chk("rand_rst_busy", 8'(busy), 8'h00);
                edge_drive();
                rst = 1'b0;
            end
        end
        edge_drive();
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
